pattern_scan_ctrl: RTL and testbench

//  Sequencer for the serial pattern-detector datapath on the DE2 board.
//  - Loads a test word and shifts it into the detector one bit per step.
//  - Generates the detector's step-enable from its own prescaler, so the detector needs no separate slow clock.
//  - Samples the detector output after every step and counts match cycles.
//  - Reports busy/done to the front panel (KEY/LEDR) logic.

---
 rtl/pattern_scan_ctrl.sv | 118 +++++++++++
 tb/tb_pattern_scan_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl.sv
// Scan sequencer for the serial pattern detector: loads a test word, steps it out MSB first
// on a prescaled enable, and counts detector matches sampled after each step.
module pattern_scan_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int WORD_W   = 16,
    parameter int CNT_W    = 8
) (
    input  logic                           CLOCK_50,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           abort,
    input  logic [WORD_W-1:0]              word_in,
    input  logic                           det_out,
    output logic                           det_in,
    output logic                           det_step,
    output logic                           busy,
    output logic                           done,
    output logic [CNT_W-1:0]               match_cnt,
    output logic [$clog2(WORD_W+1)-1:0]    bit_idx
);

    localparam int IDX_W   = $clog2(WORD_W + 1);
    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [WORD_W-1:0]   r_shift;
    logic [WORD_W-1:0]   w_shift_next;
    logic [PRESC_W-1:0]  r_presc;
    logic [PRESC_W-1:0]  w_presc_next;
    logic [CNT_W-1:0]    r_match_cnt;
    logic [CNT_W-1:0]    w_match_cnt_next;
    logic [IDX_W-1:0]    r_bit_idx;
    logic [IDX_W-1:0]    w_bit_idx_next;
    logic                w_step;
    logic                w_cnt_full;

    assign w_step     = (r_state == S_RUN) && (r_presc == PRESC_LAST);
    assign w_cnt_full = &r_match_cnt;

    always_comb begin
        w_state_next     = r_state;
        w_shift_next     = r_shift;
        w_presc_next     = r_presc;
        w_match_cnt_next = r_match_cnt;
        w_bit_idx_next   = r_bit_idx;

        // abort wins over everything; counters are left untouched for inspection
        if (abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_state_next     = S_RUN;
                        w_shift_next     = word_in;
                        w_presc_next     = '0;
                        w_match_cnt_next = '0;
                        w_bit_idx_next   = '0;
                    end
                end
                S_RUN: begin
                    if (w_step) begin
                        w_state_next = S_SAMPLE;
                        w_presc_next = '0;
                    end else begin
                        w_presc_next = r_presc + PRESC_W'(1);
                    end
                end
                S_SAMPLE: begin
                    if (det_out && !w_cnt_full) begin
                        w_match_cnt_next = r_match_cnt + CNT_W'(1);
                    end
                    w_shift_next   = {r_shift[WORD_W-2:0], 1'b0};
                    w_bit_idx_next = r_bit_idx + IDX_W'(1);
                    w_presc_next   = '0;
                    w_state_next   = (r_bit_idx == IDX_LAST) ? S_DONE : S_RUN;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_presc     <= '0;
            r_match_cnt <= '0;
            r_bit_idx   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_shift     <= w_shift_next;
            r_presc     <= w_presc_next;
            r_match_cnt <= w_match_cnt_next;
            r_bit_idx   <= w_bit_idx_next;
        end
    end

    assign det_in    = r_shift[WORD_W-1];
    assign det_step  = w_step;
    assign busy      = (r_state == S_RUN) || (r_state == S_SAMPLE);
    assign done      = (r_state == S_DONE);
    assign match_cnt = r_match_cnt;
    assign bit_idx   = r_bit_idx;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl with a behavioural detector and a result scoreboard.
module tb_pattern_scan_ctrl;

    logic        CLOCK_50 = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] word_in;
    logic        det_out;

    logic        det_in, det_step, busy, done;
    logic [7:0]  match_cnt;
    logic [4:0]  bit_idx;

    logic        c3_det_in, c3_det_step, c3_busy, c3_done;
    logic [2:0]  c3_match_cnt;
    logic [4:0]  c3_bit_idx;

    logic [2:0]  det_hist;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] word;
        logic [7:0]  cnt;
        logic [2:0]  cnt3;
    } exp_t;
    exp_t sb_q[$];

    always #5 CLOCK_50 = ~CLOCK_50;

    pattern_scan_ctrl #(.TICK_DIV(4), .WORD_W(16), .CNT_W(8)) dut (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .word_in  (word_in),
        .det_out  (det_out),
        .det_in   (det_in),
        .det_step (det_step),
        .busy     (busy),
        .done     (done),
        .match_cnt(match_cnt),
        .bit_idx  (bit_idx)
    );

    pattern_scan_ctrl #(.TICK_DIV(4), .WORD_W(16), .CNT_W(3)) dut_c3 (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .word_in  (word_in),
        .det_out  (det_out),
        .det_in   (c3_det_in),
        .det_step (c3_det_step),
        .busy     (c3_busy),
        .done     (c3_done),
        .match_cnt(c3_match_cnt),
        .bit_idx  (c3_bit_idx)
    );

    // Detector: output goes high once three consecutive 1s have been stepped in
    always @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            det_hist <= 3'b000;
            det_out  <= 1'b0;
        end else if (det_step) begin
            det_hist <= {det_hist[1:0], det_in};
            det_out  <= &{det_hist[1:0], det_in};
        end
    end

    function automatic int model_matches(input logic [15:0] w);
        int run = 0;
        int c = 0;
        for (int i = 15; i >= 0; i--) begin
            if (w[i]) run++;
            else run = 0;
            if (run >= 3) c++;
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [15:0] w, input bit push);
        exp_t e;
        int c;
        c = model_matches(w);
        e.word = w;
        e.cnt  = (c > 255) ? 8'hFF : 8'(c);
        e.cnt3 = (c > 7) ? 3'd7 : 3'(c);
        if (push) sb_q.push_back(e);
        word_in = w;
        start   = 1'b1;
    endtask

    task automatic wait_done(input bit hold, input int cycles0);
        exp_t e;
        int cycles;
        int steps;
        int last;
        bit got;
        logic [15:0] w;
        cycles = cycles0;
        steps  = 0;
        last   = 0;
        got    = 1'b0;
        w      = word_in;
        while (!got && cycles < 3000) begin
            tick();
            cycles++;
            if (cycles == 1 && !hold) start = 1'b0;
            if (det_step) begin
                if (steps < 16) check("det_in_bit", 32'(det_in), 32'(w[15-steps]));
                if (steps > 0) check("step_gap", 32'(cycles - last), 32'd5);
                last = cycles;
                steps++;
            end
            if (done) got = 1'b1;
        end
        start = 1'b0;
        check("done_seen", 32'(got), 32'd1);
        if (got) begin
            check("done_latency", 32'(cycles), 32'd81);
            check("step_count", 32'(steps), 32'd16);
            check("bit_idx_end", 32'(bit_idx), 32'd16);
            check("busy_in_done", 32'(busy), 32'd0);
            check("c3_status", 32'({c3_det_in, c3_det_step, c3_busy, c3_done}), 32'b0001);
            check("c3_bit_idx", 32'(c3_bit_idx), 32'd16);
            check("sb_depth", 32'(sb_q.size()), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("match_cnt", 32'(match_cnt), 32'(e.cnt));
                check("match_cnt_c3", 32'(c3_match_cnt), 32'(e.cnt3));
            end
        end
    endtask

    initial begin
        int steps;
        int guard;
        int extra;

        start   = 1'b0;
        abort   = 1'b0;
        word_in = 16'h0000;
        rst_n   = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_det_in", 32'(det_in), 32'd0);
        check("rst_det_step", 32'(det_step), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_match_cnt", 32'(match_cnt), 32'd0);
        check("rst_bit_idx", 32'(bit_idx), 32'd0);
        repeat (3) @(posedge CLOCK_50);
        #1 rst_n = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // All-ones word: 14 matches, 3-bit counter saturates at 7
        launch(16'hFFFF, 1'b1);
        wait_done(1'b0, 0);

        launch(16'h0000, 1'b1);
        wait_done(1'b0, 0);
        check("zero_word_done", 32'(done), 32'd1);

        launch(16'hEEEE, 1'b1);
        wait_done(1'b0, 0);

        // start held through the scan, then a fresh launch from DONE
        launch(16'h7777, 1'b1);
        wait_done(1'b1, 0);
        tick();
        check("done_holds", 32'(done), 32'd1);
        launch(16'h0000, 1'b1);
        tick();
        start = 1'b0;
        check("relaunch_done", 32'(done), 32'd0);
        check("relaunch_cnt", 32'(match_cnt), 32'd0);
        check("relaunch_idx", 32'(bit_idx), 32'd0);
        check("relaunch_busy", 32'(busy), 32'd1);
        wait_done(1'b0, 1);

        // abort once the fifth step has been sampled
        launch(16'hFFFF, 1'b0);
        steps = 0;
        guard = 0;
        while (steps < 5 && guard < 200) begin
            tick();
            guard++;
            if (guard == 1) start = 1'b0;
            if (det_step) steps++;
        end
        check("abort_reach_step5", 32'(steps), 32'd5);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bit_idx", 32'(bit_idx), 32'd5);
        check("abort_match_cnt", 32'(match_cnt), 32'd3);
        extra = 0;
        repeat (30) begin
            tick();
            if (det_step) extra++;
        end
        check("abort_no_steps", 32'(extra), 32'd0);
        check("abort_idx_hold", 32'(bit_idx), 32'd5);

        // abort has priority over start
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_over_start", 32'(busy), 32'd0);

        // reset mid-run
        launch(16'hFFFF, 1'b0);
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_outputs", 32'({det_in, det_step, busy, done}), 32'd0);
        check("arst_match_cnt", 32'(match_cnt), 32'd0);
        check("arst_bit_idx", 32'(bit_idx), 32'd0);
        repeat (2) @(posedge CLOCK_50);
        #1;
        check("arst_hold", 32'({det_step, busy, done}), 32'd0);
        rst_n = 1'b1;
        extra = 0;
        repeat (20) begin
            tick();
            if (det_step || busy || done) extra++;
        end
        check("post_reset_idle", 32'(extra), 32'd0);

        launch(16'hA5F0, 1'b1);
        wait_done(1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
